// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported memory between instruction fetch
// and the load/store path. Only one transaction is outstanding at a time. Data
// has priority, and a streak counter lets a waiting fetch win after
// STARVE_LIMIT contested data grants. A fetch response can be discarded after
// a pipeline redirect.
module memory_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  fetchRequest,
    input  logic [ADDR_WIDTH-1:0] fetchAddress,
    input  logic                  fetchFlush,
    output logic [31:0]           fetchData,
    output logic                  fetchValid,

    input  logic                  dataRead,
    input  logic                  dataWrite,
    input  logic [ADDR_WIDTH-1:0] dataAddress,
    input  logic [31:0]           dataWriteData,
    input  logic [3:0]            dataByteEnable,
    output logic [31:0]           dataReadData,
    output logic                  dataValid,

    output logic                  memRequest,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [31:0]           memWriteData,
    output logic [3:0]            memByteEnable,
    input  logic                  memReady,
    input  logic                  memResponseValid,
    input  logic [31:0]           memReadData
);

    localparam int unsigned STREAK_WIDTH = 4;
    localparam logic [STREAK_WIDTH-1:0] STREAK_MAX   = '1;
    localparam logic [STREAK_WIDTH-1:0] STREAK_LIMIT = STREAK_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } stateType;

    stateType                state;
    logic                    ownerFetch;
    logic                    dropFetch;
    logic [STREAK_WIDTH-1:0] streak;

    logic dataPending;
    logic anyPending;
    logic fetchWins;

    // Grant decision for the IDLE cycle: data first unless fetch has starved.
    always_comb begin
        dataPending = dataRead | dataWrite;
        anyPending  = dataPending | fetchRequest;
        fetchWins   = fetchRequest & (~dataPending | (streak == STREAK_LIMIT));
    end

    // Arbiter FSM with registered memory-side and response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            ownerFetch    <= 1'b0;
            dropFetch     <= 1'b0;
            streak        <= '0;
            fetchData     <= '0;
            fetchValid    <= 1'b0;
            dataReadData  <= '0;
            dataValid     <= 1'b0;
            memRequest    <= 1'b0;
            memWrite      <= 1'b0;
            memAddress    <= '0;
            memWriteData  <= '0;
            memByteEnable <= '0;
        end else begin
            fetchValid <= 1'b0;
            dataValid  <= 1'b0;
            case (state)
                IDLE: begin
                    dropFetch <= 1'b0;
                    if (anyPending) begin
                        memRequest <= 1'b1;
                        state      <= REQ;
                        if (fetchWins) begin
                            ownerFetch    <= 1'b1;
                            streak        <= '0;
                            memWrite      <= 1'b0;
                            memAddress    <= fetchAddress;
                            memWriteData  <= '0;
                            memByteEnable <= 4'b1111;
                        end else begin
                            ownerFetch    <= 1'b0;
                            memWrite      <= dataWrite;
                            memAddress    <= dataAddress;
                            memWriteData  <= dataWrite ? dataWriteData : 32'd0;
                            memByteEnable <= dataWrite ? dataByteEnable : 4'b1111;
                            if (fetchRequest) begin
                                streak <= (streak == STREAK_MAX) ? streak
                                                                 : streak + STREAK_WIDTH'(1);
                            end else begin
                                streak <= '0;
                            end
                        end
                    end
                end
                REQ: begin
                    // The request stays on the bus even if its fetch gets flushed.
                    if (fetchFlush && ownerFetch) begin
                        dropFetch <= 1'b1;
                    end
                    if (memReady) begin
                        memRequest <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (memResponseValid) begin
                        state     <= IDLE;
                        dropFetch <= 1'b0;
                        if (ownerFetch) begin
                            fetchData  <= memReadData;
                            fetchValid <= ~(dropFetch | fetchFlush);
                        end else begin
                            dataReadData <= memWrite ? 32'd0 : memReadData;
                            dataValid    <= 1'b1;
                        end
                    end else if (fetchFlush && ownerFetch) begin
                        dropFetch <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter that shares one single-ported unified memory between the instruction-fetch path and the data (load/store) path of the 5-stage core. It sits between the Fetch and Memory stages and one backing memory, replacing the split instruction and data memories. It enforces a single outstanding transaction and gives data priority, with a starvation guard for fetch. It can also discard a fetch response after a pipeline redirect.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- STARVE_LIMIT, 4, consecutive contested data grants after which a pending fetch must win (1..15).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- fetchRequest  in  1  level; fetch wants a word at fetchAddress. Held until fetchValid or fetchFlush.
- fetchAddress  in  ADDR_WIDTH  word-aligned instruction address.
- fetchFlush  in  1  1-cycle pulse on redirect/trap; the in-flight or pending fetch result is discarded.
- fetchData  out  32  instruction word; valid only with fetchValid.
- fetchValid  out  1  1-cycle pulse, fetch response.
- dataRead  in  1  level load request, held until dataValid.
- dataWrite  in  1  level store request, held until dataValid; wins if asserted together with dataRead.
- dataAddress  in  ADDR_WIDTH  load/store address.
- dataWriteData  in  32  store data.
- dataByteEnable  in  4  store byte lanes.
- dataReadData  out  32  load word; valid only with dataValid.
- dataValid  out  1  1-cycle pulse: load data returned or store completed.
- memRequest  out  1  request to memory; held with all mem* fields stable until memReady.
- memWrite  out  1  1 = store, 0 = read.
- memAddress  out  ADDR_WIDTH  memory address.
- memWriteData  out  32  store data.
- memByteEnable  out  4  store lanes; 4'b1111 for reads.
- memReady  in  1  memory accepts the request this cycle.
- memResponseValid  in  1  1-cycle pulse: read data or write acknowledge for the accepted request.
- memReadData  in  32  read data, valid with memResponseValid.

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: if any request is pending, choose an owner, latch the owner's address, data, lanes and type into the mem* registers, set memRequest, and go to REQ.
- Arbitration: data wins unless fetchRequest is asserted and streak == STARVE_LIMIT; then fetch wins.
- streak is a 4-bit counter:
  - +1, saturating, on a data grant while fetchRequest is asserted.
  - cleared on a fetch grant.
  - cleared on a data grant with no fetch pending.
- REQ: hold all mem* outputs. When memReady is high, drop memRequest and go to WAIT. A request is never retracted, even when flushed.
- WAIT: when memResponseValid is high, return to IDLE and register the response:
  - owner = data: dataReadData <= memReadData (zero for stores); dataValid <= 1.
  - owner = fetch: fetchData <= memReadData; fetchValid <= 1, unless the drop flag is set.
- Drop flag:
  - set by fetchFlush in REQ or WAIT while the owner is fetch;
  - also set by fetchFlush in the same cycle as memResponseValid;
  - cleared on return to IDLE.
- fetchFlush in IDLE has no effect: the new fetchAddress is used at the next grant.
- memResponseValid in IDLE or REQ is ignored. This covers a stale response after reset.
- The arbiter never issues a second request before the previous response arrives.

## Timing
- Reset values: all outputs 0, state IDLE, streak 0, drop flag 0.
- Request seen in IDLE at cycle N → memRequest high at N+1.
- memReady at cycle M ≥ N+1 → memRequest low at M+1.
- memResponseValid at cycle R > M → fetchValid or dataValid high exactly at R+1; state is IDLE at R+1.
- Next grant is decided at R+1 and its memRequest rises at R+2.
- Minimum request-to-valid latency, with memReady immediate and a 1-cycle memory, is 3 cycles.
- Request inputs are sampled only in IDLE. Changes during REQ or WAIT do not affect the current transaction.
- Reset has priority over every event, including mid-REQ and mid-WAIT.

## Test plan
- Lone fetch: fetchRequest with fetchAddress 0x100; memory returns 0x00500093 one cycle after acceptance → memRequest=1, memWrite=0, memAddress=0x100; fetchValid pulses once with fetchData 0x00500093, 3 cycles after the request.
- Contention: fetchRequest and dataRead (0x2000) held continuously → data granted STARVE_LIMIT=4 times, then 1 fetch grant, then data again; streak returns to 0 after the fetch grant.
- Store: dataWrite to 0x2004, data 0xDEADBEEF, lanes 4'b0011, memReady delayed 3 cycles → mem* fields stable throughout REQ; a single dataValid pulse follows memResponseValid.
- Flush: fetchFlush while in WAIT for a fetch → no fetchValid pulse; the next fetch to 0x200 is granted normally with correct data. A flush in IDLE changes nothing.
- Reset mid-WAIT: assert reset, then memResponseValid arrives → all outputs 0, no valid pulse, state IDLE.
- dataRead and dataWrite asserted together → memWrite=1; exactly one dataValid pulse.
